// File: rtl/vx_div_sched_if.sv
// Bundle of requester, response and divider-side signals for the divide scheduler.
// master = scheduler, slave = requesters/consumer/divider environment.
interface vx_div_sched_if #(
  parameter int NUM_REQS  = 4,
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 8
);
  localparam int RIDW = $clog2(NUM_REQS);

  logic [NUM_REQS-1:0]           req_valid;
  logic [NUM_REQS-1:0]           req_ready;
  logic [NUM_REQS*WIDTH-1:0]     req_numer;
  logic [NUM_REQS*WIDTH-1:0]     req_denom;
  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH-1:0]     rsp_quotient;
  logic [WIDTH-1:0]     rsp_remainder;
  logic [TAG_WIDTH-1:0] rsp_tag;
  logic [RIDW-1:0]      rsp_reqid;

  logic [WIDTH-1:0] div_numer;
  logic [WIDTH-1:0] div_denom;
  logic             div_clken;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  modport master (
    input  req_valid, req_numer, req_denom, req_tag, rsp_ready, div_quotient, div_remainder,
    output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_reqid,
           div_numer, div_denom, div_clken
  );

  modport slave (
    output req_valid, req_numer, req_denom, req_tag, rsp_ready, div_quotient, div_remainder,
    input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_reqid,
           div_numer, div_denom, div_clken
  );
endinterface

// File: rtl/vx_div_sched.sv
// Round-robin front end sharing one fixed-latency divider among NUM_REQS requesters.
// Shadow pipeline tracks tag/reqid alongside the divider and patches divide-by-zero.
module vx_div_sched #(
  parameter int NUM_REQS  = 4,
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 8,
  parameter int PIPELINE  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  vx_div_sched_if.master bus
);
  localparam int RIDW = $clog2(NUM_REQS);

  typedef struct packed {
    logic                 vld;
    logic                 dbz;
    logic [RIDW-1:0]      rid;
    logic [TAG_WIDTH-1:0] tag;
    logic [WIDTH-1:0]     numer;
  } shadow_t;

  shadow_t [PIPELINE-1:0] sh_q, sh_d;
  shadow_t                sh_in, sh_out;
  logic [RIDW-1:0]        rr_q, rr_d, gnt_idx;
  logic [RIDW:0]          rr_sum;
  logic                   gnt_vld, stall, accept;
  logic [WIDTH-1:0]       gnt_numer, gnt_denom;
  logic [TAG_WIDTH-1:0]   gnt_tag;

  assign sh_out = sh_q[PIPELINE-1];
  assign stall  = sh_out.vld & ~bus.rsp_ready;
  assign accept = gnt_vld & ~stall;

  // Scan offsets high to low so the nearest valid requester after rr_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_q} + (RIDW+1)'(k);
      if (rr_sum >= (RIDW+1)'(NUM_REQS)) rr_sum = rr_sum - (RIDW+1)'(NUM_REQS);
      if (bus.req_valid[rr_sum[RIDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_sum[RIDW-1:0];
      end
    end
    if (!rst_n) gnt_vld = 1'b0;
  end

  assign gnt_numer = gnt_vld ? bus.req_numer[gnt_idx*WIDTH +: WIDTH]         : '0;
  assign gnt_denom = gnt_vld ? bus.req_denom[gnt_idx*WIDTH +: WIDTH]         : '0;
  assign gnt_tag   = gnt_vld ? bus.req_tag[gnt_idx*TAG_WIDTH +: TAG_WIDTH]   : '0;

  always_comb begin
    sh_in.vld   = gnt_vld;
    sh_in.dbz   = gnt_vld && (gnt_denom == '0);
    sh_in.rid   = gnt_idx;
    sh_in.tag   = gnt_tag;
    sh_in.numer = gnt_numer;
    sh_d        = sh_q;
    sh_d[0]     = sh_in;
    for (int i = 1; i < PIPELINE; i++) sh_d[i] = sh_q[i-1];
    rr_d = rr_q;
    if (accept) rr_d = (gnt_idx == RIDW'(NUM_REQS - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      sh_q <= '0;
    end else begin
      rr_q <= rr_d;
      if (!stall) sh_q <= sh_d;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign bus.div_clken     = ~stall;
  assign bus.div_numer     = gnt_numer;
  assign bus.div_denom     = gnt_denom;
  assign bus.rsp_valid     = sh_out.vld;
  assign bus.rsp_tag       = sh_out.tag;
  assign bus.rsp_reqid     = sh_out.rid;
  assign bus.rsp_quotient  = sh_out.dbz ? '1 : bus.div_quotient;
  assign bus.rsp_remainder = sh_out.dbz ? sh_out.numer : bus.div_remainder;
endmodule

// File: doc/vx_div_sched.md
VX_DIV_SCHED -- requirements
Module: VX_div_sched

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of requesters sharing one divider, range 2..16.
REQ-002 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-003 SHALL have parameter TAG_WIDTH, default 8: opaque requester tag width.
REQ-004 SHALL have parameter PIPELINE, default 3: fixed latency of the attached VX_divide in clken-enabled cycles, range 1..8.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid, input, NUM_REQS: per-requester request valid.
REQ-008 SHALL have port req_numer, input, NUM_REQS*WIDTH: packed dividends, requester i at [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_denom, input, NUM_REQS*WIDTH: packed divisors.
REQ-010 SHALL have port req_tag, input, NUM_REQS*TAG_WIDTH: packed tags.
REQ-011 SHALL have port req_ready, output, NUM_REQS: per-requester accept.
REQ-012 SHALL have port rsp_valid, output, 1: result valid.
REQ-013 SHALL have port rsp_ready, input, 1: consumer accept.
REQ-014 SHALL have ports rsp_quotient and rsp_remainder, output, WIDTH each: results.
REQ-015 SHALL have port rsp_tag, output, TAG_WIDTH, and port rsp_reqid, output, clog2(NUM_REQS): originating tag and requester index.
REQ-016 SHALL have ports div_numer and div_denom, output, WIDTH each: divider operands.
REQ-017 SHALL have port div_clken, output, 1: divider pipeline enable.
REQ-018 SHALL have ports div_quotient and div_remainder, input, WIDTH each: divider results.

Function
REQ-019 Handshake: a transfer SHALL occur on a cycle where valid and ready are both 1; requesters hold valid and operands stable until accepted.
REQ-020 Stall: stall = rsp_valid & ~rsp_ready; div_clken SHALL be ~stall, combinational.
REQ-021 Arbitration SHALL be round-robin: priority starts at the requester after the last granted one, wrapping NUM_REQS-1 -> 0; at most one req_ready bit high per cycle.
REQ-022 req_ready[i] SHALL be high only when requester i is granted and stall is 0; a requester with req_valid low SHALL never be granted.
REQ-023 Each cycle with div_clken=1, div_numer/div_denom SHALL carry the granted requester's operands, zero when no grant.
REQ-024 Tracking: shadow registers of depth PIPELINE (valid, tag, reqid, dbz flag, numerator) SHALL shift one stage per cycle with div_clken=1 and hold otherwise.
REQ-025 Latency: a request accepted at cycle t with no stall SHALL produce rsp_valid at cycle t+PIPELINE; each stall cycle adds one cycle.
REQ-026 rsp_valid SHALL equal the last shadow valid stage; rsp_quotient/rsp_remainder SHALL pass div_quotient/div_remainder through.
REQ-027 Divide-by-zero (denom=0) SHALL give rsp_quotient all ones and rsp_remainder equal to the numerator, overriding divider outputs.
REQ-028 Throughput: one request per cycle when rsp_ready stays high; no bubbles from the scheduler.
REQ-029 Responses SHALL emerge in acceptance order; no drop or duplication.
REQ-030 Round-robin pointer SHALL update only on an accepted request.

Reset
REQ-031 While rst_n=0, all shadow valids, the round-robin pointer (requester 0 highest priority) and outputs SHALL clear asynchronously: rsp_valid=0, req_ready=0, div_clken=1, div_numer=div_denom=0, rsp_tag=rsp_reqid=0.
REQ-032 Reset mid-operation SHALL discard all in-flight requests; no response for them after rst_n deasserts.
REQ-033 First grant SHALL be possible in the first clock edge after rst_n rises.

Verification
REQ-034 PIPELINE=3, requester 0 sends 56/11 tag 0x5A, rsp_ready=1 -> 3 cycles later rsp_valid=1, quotient 5, remainder 1, tag 0x5A, reqid 0.
REQ-035 All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; responses in same reqid order.
REQ-036 Requester 2 sends 100/0 -> rsp quotient 0xFFFFFFFF, remainder 100, reqid 2.
REQ-037 Back-to-back requests, rsp_ready low 4 cycles with rsp_valid=1 -> div_clken=0, req_ready all 0, rsp fields held stable; after release all results delivered, in order, none lost.
REQ-038 Two requests in flight, rst_n pulsed low -> rsp_valid=0 immediately and no response ever returns for them; next request after reset served by requester 0 first.
REQ-039 Random 10k operations, random rsp_ready -> every quotient/remainder matches a reference model, count of responses equals count of accepts.
